regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/regfile_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// FSM state encoding, default widths and the grant counter width.
package regfile_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin selector: picks the single valid requester, or the one
// named by ptr when both are valid. Grant is one-hot, or zero when disabled.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter giving two requesters access to a single-port register
// file: IDLE (grant) -> ISSUE (drive RF) -> RESP (return data), one cycle each.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_addr,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic                  busy,
    output logic [2*CNT_W-1:0]    grant_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_e                   state_q, state_d;
    logic                     rr_ptr_q, rr_ptr_d;
    logic                     gnt_idx_q, gnt_idx_d;
    logic                     we_q, we_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]               grant;
    logic                     arb_en;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter2 u_rr_arbiter2 (
        .valid  (req_valid),
        .ptr    (rr_ptr_q),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready = grant;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d   = ST_ISSUE;
                    gnt_idx_d = grant[1];
                    rr_ptr_d  = ~grant[1];
                    we_d      = grant[1] ? req_we[1] : req_we[0];
                    addr_d    = grant[1] ? req_addr[2*ADDR_W-1:ADDR_W]
                                         : req_addr[ADDR_W-1:0];
                    wdata_d   = grant[1] ? req_wdata[2*DATA_W-1:DATA_W]
                                         : req_wdata[DATA_W-1:0];
                    if (grant[0]) cnt_d[0] = sat_inc(cnt_q[0]);
                    if (grant[1]) cnt_d[1] = sat_inc(cnt_q[1]);
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The latched address/data double as the RF-facing registers, so they hold
    // their value everywhere except at the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        gnt_idx_q <= gnt_idx_d;
        we_q      <= we_d;
    end

    // Reset gates the strobes combinationally so an in-flight transaction dies quietly.
    assign rf_we     = (state_q == ST_ISSUE) && we_q && !rst;
    assign rf_addr   = addr_q;
    assign rf_wdata  = wdata_q;
    assign rsp_valid = ((state_q == ST_RESP) && !rst) ? (gnt_idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = ((state_q == ST_RESP) && !rst && !we_q) ? rf_rdata : '0;
    assign busy      = (state_q != ST_IDLE);
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a registered-read register-file model.
module tb_regfile_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [DW-1:0]   rf_wdata;
    logic [DW-1:0]   rf_rdata;
    logic            busy;
    logic [31:0]     grant_cnt;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int n_total = 0;
    int n_bad   = 0;

    regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rf_rdata = '0;
    end

    always @(posedge clk) begin
        if (rf_we) mem[rf_addr] <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1 chk("rst_ready", req_ready, 2'b00);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_grant_cnt", grant_cnt, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        rst = 1'b0;
    endtask

    // Presents one request in IDLE and checks the ISSUE and RESP cycles that follow.
    task automatic do_req(input int r, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int n;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r*AW +: AW]  = addr;
        req_wdata[r*DW +: DW] = wd;
        n = 0;
        #1;
        while (req_ready[r] !== 1'b1 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", req_ready[r], 1);
        if (req_ready[r] !== 1'b1) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        chk("issue_busy", busy, 1);
        chk("issue_rf_we", rf_we, we);
        chk("issue_rf_addr", rf_addr, addr);
        if (we) chk("issue_rf_wdata", rf_wdata, wd);
        chk("issue_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("resp_valid", rsp_valid, (r == 1) ? 2'b10 : 2'b01);
        chk("resp_rdata", rsp_rdata, exp_rd);
        chk("resp_rf_we", rf_we, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        apply_reset();

        // Write then read from requester 0.
        do_req(0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0);
        do_req(0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF);
        chk("cnt_after_wr_rd", grant_cnt, {16'd0, 16'd2});

        // Both requesters valid continuously: grants alternate starting with 0.
        apply_reset();
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {10'h002, 10'h001};
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("alt_ready", req_ready,
                (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            chk("alt_rsp", rsp_valid,
                (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1 chk("alt_cnt", grant_cnt, {16'd2, 16'd2});

        // Boundary addresses from requester 1.
        do_req(1, 1'b1, 10'h000, 32'hA5A5A5A5, 32'h0);
        do_req(1, 1'b1, 10'h3FF, 32'h5A5A5A5A, 32'h0);
        do_req(1, 1'b0, 10'h000, 32'h0, 32'hA5A5A5A5);
        do_req(1, 1'b0, 10'h3FF, 32'h0, 32'h5A5A5A5A);

        // Reset during the ISSUE cycle of a write.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[AW-1:0]  = 10'h3FF;
        req_wdata[DW-1:0] = 32'h00001234;
        #1 chk("midwr_accept", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        #1 chk("midwr_rf_we", rf_we, 0);
        @(negedge clk);
        #1;
        chk("midwr_busy", busy, 0);
        chk("midwr_rsp", rsp_valid, 0);
        chk("midwr_rf_addr", rf_addr, 0);
        chk("midwr_cnt", grant_cnt, 0);
        rst = 1'b0;
        do_req(0, 1'b0, 10'h3FF, 32'h0, 32'h5A5A5A5A);

        // Reset during RESP suppresses the response.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[2*AW-1:AW] = 10'h000;
        #1 chk("midrsp_accept", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrsp_rsp", rsp_valid, 0);
        chk("midrsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // A request raised and dropped while the arbiter is busy never transfers.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[AW-1:0]  = 10'h00A;
        req_wdata[DW-1:0] = 32'h00000077;
        #1 chk("drop_accept0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b10;
        req_we[1] = 1'b0;
        #1 chk("drop_ready_issue", req_ready, 2'b00);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("drop_ready_resp", req_ready, 2'b00);
        @(negedge clk);
        #1 chk("drop_idle_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("drop_still_idle", busy, 0);
        chk("drop_cnt", grant_cnt, {16'd0, 16'd1});

        // Counter saturation from a preloaded value.
        force dut.cnt_q = {16'd0, 16'hFFFE};
        #1 release dut.cnt_q;
        do_req(0, 1'b0, 10'h00A, 32'h0, 32'h00000077);
        chk("sat_first", grant_cnt[15:0], 16'hFFFF);
        do_req(0, 1'b0, 10'h00A, 32'h0, 32'h00000077);
        do_req(0, 1'b0, 10'h00A, 32'h0, 32'h00000077);
        chk("sat_hold", grant_cnt[15:0], 16'hFFFF);
        chk("sat_other", grant_cnt[31:16], 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
